// File: rtl/icap_scheduler.sv
`timescale 1ns/1ps
// Sole owner of the ICAPE2 port: sequences WBSTAR+IPROG reboots and configuration
// register reads, applying per-byte bit reversal on both data directions.
module icap_scheduler #(
  parameter int READ_LAT = 3,
  parameter int NOP_TAIL = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reboot_req,
  input  logic [31:0] reboot_addr,
  input  logic        rd_req,
  input  logic [4:0]  rd_reg,
  output logic        rd_ack,
  output logic        rd_done,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        halted,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o
);

  localparam logic [7:0] RD_LAST   = 8'(READ_LAT - 1);
  localparam logic [7:0] BOOT_LAST = 8'(6 + NOP_TAIL);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_PRO,
    S_RD_GAP1,
    S_RD_GAP2,
    S_RD_WAIT,
    S_RD_END1,
    S_RD_END2,
    S_RD_DSYNC,
    S_BOOT,
    S_HALT
  } state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n, cnt_inc;
  logic [4:0]  reg_q, reg_n;
  logic [31:0] addr_q;
  logic        pend;
  logic        csib_n, rdwrb_n, ack_n, done_n, busy_n, halted_n;
  logic [31:0] word_n;

  function automatic logic [31:0] swap_bits(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b + i] = w[8*b + 7 - i];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rd_pro_word(input logic [2:0] idx, input logic [4:0] r);
    case (idx)
      3'd0:    return 32'hAA995566;
      3'd1:    return 32'h20000000;
      3'd2:    return 32'h28000001 | ({27'd0, r} << 13);
      default: return 32'h20000000;
    endcase
  endfunction

  function automatic logic [31:0] desync_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return 32'h30008001;
      2'd1:    return 32'h0000000D;
      default: return 32'h20000000;
    endcase
  endfunction

  // Indices past the IPROG command fall through to the NOP tail.
  function automatic logic [31:0] boot_word(input logic [7:0] idx, input logic [31:0] a);
    case (idx)
      8'd0:    return 32'hFFFFFFFF;
      8'd1:    return 32'hAA995566;
      8'd2:    return 32'h20000000;
      8'd3:    return 32'h30020001;
      8'd4:    return a;
      8'd5:    return 32'h30008001;
      8'd6:    return 32'h0000000F;
      default: return 32'h20000000;
    endcase
  endfunction

  assign cnt_inc = cnt + 8'd1;

  // Next-state logic computes the values the registered pins show next cycle.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    reg_n    = reg_q;
    csib_n   = 1'b1;
    rdwrb_n  = 1'b0;
    word_n   = 32'hFFFFFFFF;
    ack_n    = 1'b0;
    done_n   = 1'b0;
    busy_n   = 1'b1;
    halted_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend || reboot_req) begin
          state_n = S_BOOT;
          cnt_n   = 8'd0;
          csib_n  = 1'b0;
          word_n  = boot_word(8'd0, addr_q);
        end else if (rd_req) begin
          state_n = S_RD_PRO;
          cnt_n   = 8'd0;
          reg_n   = rd_reg;
          ack_n   = 1'b1;
          csib_n  = 1'b0;
          word_n  = rd_pro_word(3'd0, rd_reg);
        end else begin
          busy_n = 1'b0;
        end
      end
      S_RD_PRO: begin
        if (cnt == 8'd4) begin
          state_n = S_RD_GAP1;
        end else begin
          cnt_n  = cnt_inc;
          csib_n = 1'b0;
          word_n = rd_pro_word(cnt_inc[2:0], reg_q);
        end
      end
      S_RD_GAP1: begin
        state_n = S_RD_GAP2;
        rdwrb_n = 1'b1;
      end
      S_RD_GAP2: begin
        state_n = S_RD_WAIT;
        cnt_n   = 8'd0;
        csib_n  = 1'b0;
        rdwrb_n = 1'b1;
      end
      S_RD_WAIT: begin
        rdwrb_n = 1'b1;
        if (cnt == RD_LAST) begin
          state_n = S_RD_END1;
        end else begin
          cnt_n  = cnt_inc;
          csib_n = 1'b0;
        end
      end
      S_RD_END1: begin
        state_n = S_RD_END2;
      end
      S_RD_END2: begin
        state_n = S_RD_DSYNC;
        cnt_n   = 8'd0;
        csib_n  = 1'b0;
        word_n  = desync_word(2'd0);
      end
      S_RD_DSYNC: begin
        if (cnt == 8'd3) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          cnt_n  = cnt_inc;
          csib_n = 1'b0;
          word_n = desync_word(cnt_inc[1:0]);
        end
      end
      S_BOOT: begin
        if (cnt == BOOT_LAST) begin
          state_n  = S_HALT;
          halted_n = 1'b1;
        end else begin
          cnt_n  = cnt_inc;
          csib_n = 1'b0;
          word_n = boot_word(cnt_inc, addr_q);
        end
      end
      S_HALT: begin
        halted_n = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b0;
      icap_i     <= 32'hFFFFFFFF;
      rd_ack     <= 1'b0;
      rd_done    <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      icap_csib  <= csib_n;
      icap_rdwrb <= rdwrb_n;
      icap_i     <= swap_bits(word_n);
      rd_ack     <= ack_n;
      rd_done    <= done_n;
      busy       <= busy_n;
      halted     <= halted_n;
    end
  end

  // Entering the reboot consumes the pending request, even one arriving that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (state == S_IDLE && (pend || reboot_req)) begin
      pend <= 1'b0;
    end else if (reboot_req && state != S_HALT) begin
      pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    reg_q <= reg_n;
    if (reboot_req && state != S_HALT) begin
      addr_q <= reboot_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 32'd0;
    end else if (state == S_RD_WAIT && cnt == RD_LAST) begin
      rd_data <= swap_bits(icap_o);
    end
  end

endmodule
